logic_op_sched: RTL and testbench
=================================

Name: logic_op_sched

Overview:
- Two-requester scheduler that shares one combinational inverting logic unit (AND/OR/XOR plus conditional invert) between two independent clients.
- Arbitrates round-robin, registers operands and control selects toward the unit, captures the unit result, and returns it with the winning requester's ID and tag.
- Two-stage pipeline: issue stage, then result stage.
- Full backpressure on the response side.
- Sits between the ALU front-end issue logic and the shared logic unit instance.

Parameters:
- WIDTH, 8, operand/result width; must match the logic unit's WIDTH.
- TAG_W, 4, width of the opaque requester tag carried with each operation.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_op  input  3  op[1:0]: 00 AND, 01 OR, 10 XOR, 11 reserved; op[2]: invert result
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_tag  input  TAG_W  opaque tag, returned unchanged
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as requester 0, for requester 1
- lu_c_and  output  1  registered AND select to logic unit
- lu_c_or  output  1  registered OR select
- lu_c_xor  output  1  registered XOR select
- lu_c_inv  output  1  registered invert select
- lu_a  output  WIDTH  registered operand A to unit
- lu_b  output  WIDTH  registered operand B to unit
- lu_out  input  WIDTH  combinational result from unit
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response when valid&ready
- rsp_data  output  WIDTH  result
- rsp_id  output  1  requester that issued the operation
- rsp_tag  output  TAG_W  tag of the operation
- rsp_err  output  1  1 = reserved opcode; rsp_data forced to 0

Behaviour:
Reset:
- All outputs and state clear on rst assertion, independent of clk.
- All lu_* outputs and rsp_* outputs are 0; req*_ready is 0 while rst is high.
- Round-robin pointer resets to favour requester 0.
- Any in-flight operation is discarded; no partial response after reset release.

Pipeline registers:
- S1 (issue): s1_valid, lu_* controls, operands, id, tag, err.
- S2 (result): rsp_* fields.
- adv2 = !rsp_valid | rsp_ready.
- adv1 = !s1_valid | adv2.

Arbitration, evaluated combinationally each cycle when adv1=1:
- Only one requester valid: grant it.
- Both valid: grant the requester favoured by the pointer.
- req_k_ready = adv1 & grant_k; at most one ready per cycle.
- Pointer changes only on a handshake: it then favours the non-granted requester.
- When adv1=0, both ready outputs are 0 and the pointer holds.
- Ready never depends on rsp_valid of the same cycle beyond adv1; no combinational loop through lu_out.

Issue (S1 load on handshake):
- Controls are one-hot select plus inv: c_and=(op[1:0]==00), c_or=(01), c_xor=(10), c_inv=op[2].
- Reserved op[1:0]=11: all selects and c_inv are 0, err=1.
- With no handshake and adv1=1: s1_valid<=0, and lu_* controls are cleared to 0 (idle unit).
- With adv1=0: S1 holds and lu_* stay stable.

Result (S2 load when adv2 & s1_valid):
- rsp_data <= err ? 0 : lu_out; rsp_id, rsp_tag, rsp_err copied from S1.
- rsp_valid <= 1.
- If adv2 and !s1_valid: rsp_valid <= 0.
- While rsp_valid & !rsp_ready: all rsp_* hold stable.

Latency and throughput:
- Handshake at cycle N gives rsp_valid at cycle N+2.
- With rsp_ready held high, sustained throughput is 1 op/cycle.
- Backpressure: stalls fill S2 then S1, after which both ready outputs drop. Up to 2 ops are buffered; no ops are lost or duplicated.
- Responses return in acceptance order.

Test Plan:
- Reset mid-stream: S1 and S2 both full, pulse rst asynchronously between edges -> rsp_valid and all lu_* go 0 immediately; the first response after release comes from a new request only.
- Single op: req0 op=3'b000, a=8'hF0, b=8'h3C, tag=5, rsp_ready=1 -> at N+2: rsp_data=8'h30, id=0, tag=5, err=0; lu_c_and=1 at N+1.
- Invert ops: op=3'b110 (XNOR) with a=8'hAA, b=8'h0F -> rsp_data=8'h5A; op=3'b101 (NOR) with a=8'h01, b=8'h02 -> 8'hFC.
- Fairness: both requesters continuously valid for 6 ops, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; rsp_id follows the same order.
- Backpressure: rsp_ready=0 while issuing 3 ops from req1 -> exactly 2 accepted, then req1_ready=0; rsp_* stay stable. Raise rsp_ready -> 3rd op accepted, all 3 responses delivered in order.
- Reserved opcode: op=3'b011, a=b=8'hFF -> rsp_err=1, rsp_data=8'h00, and no select line was asserted at issue.

Source files
------------

// File: rtl/logic_op_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : logic_op_sched                                                |
// | Purpose  : Round-robin scheduler sharing one combinational logic unit    |
// |            (AND/OR/XOR + conditional invert) between two requesters.     |
// |            Two-stage pipeline: S1 drives the unit, S2 holds the response.|
// | Ports    : clk, rst                  - clock, async active-high reset    |
// |            req{0,1}_valid/ready/op/a/b/tag - requester channels          |
// |            lu_c_and/or/xor/inv, lu_a, lu_b - registered unit controls    |
// |            lu_out                    - combinational unit result         |
// |            rsp_valid/ready/data/id/tag/err - response channel            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module logic_op_sched #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             lu_c_and,
  output logic             lu_c_or,
  output logic             lu_c_xor,
  output logic             lu_c_inv,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Issue stage (S1)
  logic             s1_valid_q, s1_valid_d;
  logic             c_and_q, c_and_d;
  logic             c_or_q, c_or_d;
  logic             c_xor_q, c_xor_d;
  logic             c_inv_q, c_inv_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  // Result stage (S2)
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  // Round-robin pointer: 0 favours requester 0, 1 favours requester 1
  logic             rr_q, rr_d;

  logic             adv1, adv2;
  logic             grant0, grant1;
  logic             hs;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;

  // Arbitration and handshake
  always_comb begin
    adv2   = !rsp_valid_q || rsp_ready;
    adv1   = !s1_valid_q || adv2;
    grant0 = req0_valid && (!req1_valid || !rr_q);
    grant1 = req1_valid && (!req0_valid || rr_q);
    // Ready is also masked by rst so nothing is accepted while reset is held,
    // even though the cleared pipeline would otherwise report space.
    req0_ready = adv1 && grant0 && !rst;
    req1_ready = adv1 && grant1 && !rst;
    hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_op     = grant1 ? req1_op  : req0_op;
    sel_a      = grant1 ? req1_a   : req0_a;
    sel_b      = grant1 ? req1_b   : req0_b;
    sel_tag    = grant1 ? req1_tag : req0_tag;
  end

  // Pointer and S1 next state
  always_comb begin
    rr_d       = rr_q;
    s1_valid_d = s1_valid_q;
    c_and_d    = c_and_q;
    c_or_d     = c_or_q;
    c_xor_d    = c_xor_q;
    c_inv_d    = c_inv_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    tag_d      = tag_q;
    err_d      = err_q;
    if (adv1) begin
      if (hs) begin
        // Favour the requester that lost (or did not compete) next time
        rr_d       = grant0;
        s1_valid_d = 1'b1;
        c_and_d    = (sel_op[1:0] == OP_AND);
        c_or_d     = (sel_op[1:0] == OP_OR);
        c_xor_d    = (sel_op[1:0] == OP_XOR);
        // Reserved opcode leaves the unit fully idle, invert included
        c_inv_d    = sel_op[2] && (sel_op[1:0] != OP_RSV);
        err_d      = (sel_op[1:0] == OP_RSV);
        a_d        = sel_a;
        b_d        = sel_b;
        id_d       = grant1;
        tag_d      = sel_tag;
      end else begin
        // Bubble: idle the unit; operands keep their last value
        s1_valid_d = 1'b0;
        c_and_d    = 1'b0;
        c_or_d     = 1'b0;
        c_xor_d    = 1'b0;
        c_inv_d    = 1'b0;
        err_d      = 1'b0;
      end
    end
  end

  // S2 next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (adv2) begin
      if (s1_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = err_q ? '0 : lu_out;
        rsp_id_d    = id_q;
        rsp_tag_d   = tag_q;
        rsp_err_d   = err_q;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= 1'b0;
      s1_valid_q  <= 1'b0;
      c_and_q     <= 1'b0;
      c_or_q      <= 1'b0;
      c_xor_q     <= 1'b0;
      c_inv_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      s1_valid_q  <= s1_valid_d;
      c_and_q     <= c_and_d;
      c_or_q      <= c_or_d;
      c_xor_q     <= c_xor_d;
      c_inv_q     <= c_inv_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign lu_c_and  = c_and_q;
  assign lu_c_or   = c_or_q;
  assign lu_c_xor  = c_xor_q;
  assign lu_c_inv  = c_inv_q;
  assign lu_a      = a_q;
  assign lu_b      = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_logic_op_sched                                             |
// | Purpose  : Directed self-checking bench for logic_op_sched, including a  |
// |            behavioural model of the shared logic unit.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_logic_op_sched;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             lu_c_and, lu_c_or, lu_c_xor, lu_c_inv;
  logic [WIDTH-1:0] lu_a, lu_b, lu_out;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic_op_sched #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .lu_c_and   (lu_c_and),
    .lu_c_or    (lu_c_or),
    .lu_c_xor   (lu_c_xor),
    .lu_c_inv   (lu_c_inv),
    .lu_a       (lu_a),
    .lu_b       (lu_b),
    .lu_out     (lu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared logic unit model
  logic [WIDTH-1:0] lu_res;
  always_comb begin
    lu_res = '0;
    if (lu_c_and) lu_res = lu_res | (lu_a & lu_b);
    if (lu_c_or)  lu_res = lu_res | (lu_a | lu_b);
    if (lu_c_xor) lu_res = lu_res | (lu_a ^ lu_b);
    lu_out = lu_c_inv ? ~lu_res : lu_res;
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             id;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Record every response the consumer takes (inputs are stable at negedge)
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready)
      got_q.push_back({rsp_data, rsp_id, rsp_tag, rsp_err});
  end

  task automatic drive(input int k, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag);
    if (k == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge
  task automatic send(input int k, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] tag,
                      input logic [7:0] exp_data, input logic exp_err);
    bit done;
    done = 1'b0;
    drive(k, op, a, b, tag);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((k == 0 && req0_ready) || (k == 1 && req1_ready)) done = 1'b1;
      @(posedge clk); #1;
    end
    if (k == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("send_accept", 32'(done), 32'd1);
    if (done) exp_q.push_back({exp_data, 1'(k), tag, exp_err});
  endtask

  task automatic drain_and_compare(input string name);
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) begin
      @(posedge clk); #1;
    end
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
      check({name, "_id"},   32'(got_q[i].id),   32'(exp_q[i].id));
      check({name, "_tag"},  32'(got_q[i].tag),  32'(exp_q[i].tag));
      check({name, "_err"},  32'(got_q[i].err),  32'(exp_q[i].err));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] fair_seq;
  int         n;
  int         acc;

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;

    // Reset state: ready held low even with a valid request pending
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_lu_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'd0);
    check("rst_lu_a", 32'(lu_a), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    req0_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Single AND op with latency check
    rsp_ready = 1'b1;
    send(0, 3'b000, 8'hF0, 8'h3C, 4'd5, 8'h30, 1'b0);
    check("single_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'b1000);
    check("single_lu_a", 32'(lu_a), 32'hF0);
    check("single_lu_b", 32'(lu_b), 32'h3C);
    @(posedge clk); #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_data", 32'(rsp_data), 32'h30);
    drain_and_compare("single");

    // Invert ops: XNOR then NOR (leaves pointer favouring requester 0)
    send(0, 3'b110, 8'hAA, 8'h0F, 4'd1, 8'h5A, 1'b0);
    check("xnor_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'b0011);
    send(1, 3'b101, 8'h01, 8'h02, 4'd2, 8'hFC, 1'b0);
    drain_and_compare("invert");

    // Fairness: both valid continuously; grants 0,1,0,1,0,1 (bit n)
    fair_seq = 6'b101010;
    n = 0;
    drive(0, 3'b000, 8'hF0, 8'h3C, 4'd1);
    drive(1, 3'b001, 8'hF0, 8'h0F, 4'd2);
    for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("fair_onehot", 32'(req0_ready && req1_ready), 32'd0);
        check("fair_grant", 32'(req1_ready), 32'(fair_seq[n]));
        if (fair_seq[n]) exp_q.push_back({8'hFF, 1'b1, 4'd2, 1'b0});
        else             exp_q.push_back({8'h30, 1'b0, 4'd1, 1'b0});
        n++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("fair_count", 32'(n), 32'd6);
    drain_and_compare("fair");

    // Backpressure: three XOR ops from req1 with the consumer stalled
    rsp_ready = 1'b0;
    acc = 0;
    drive(1, 3'b010, 8'hFF, 8'h0F, 4'd7);
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      #1;
      if (cyc == 6) begin
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_ready1", 32'(req1_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_tag", 32'(rsp_tag), 32'd7);
        check("bp_rsp_data", 32'(rsp_data), 32'hF0);
        rsp_ready = 1'b1;
        #1;
      end
      if (req1_ready) begin
        exp_q.push_back({8'hF0, 1'b1, 4'(7 + acc), 1'b0});
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) req1_tag = 4'(7 + acc);
    end
    req1_valid = 1'b0;
    check("bp_total", 32'(acc), 32'd3);
    drain_and_compare("bp");

    // Reserved opcodes: no selects, err set, data forced to zero
    send(0, 3'b011, 8'hFF, 8'hFF, 4'd3, 8'h00, 1'b1);
    check("rsv_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'd0);
    send(1, 3'b111, 8'hFF, 8'h00, 4'd4, 8'h00, 1'b1);
    check("rsv_inv_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'd0);
    drain_and_compare("rsv");

    // Reset mid-stream with S1 and S2 both full
    rsp_ready = 1'b0;
    send(0, 3'b001, 8'h0F, 8'hF0, 4'hA, 8'hFF, 1'b0);
    send(1, 3'b010, 8'h33, 8'h0F, 4'hB, 8'h3C, 1'b0);
    check("mid_s2_full", 32'(rsp_valid), 32'd1);
    check("mid_s1_full", 32'(lu_c_xor), 32'd1);
    drive(0, 3'b000, 8'h55, 8'h55, 4'hD);
    #2 rst = 1'b1;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_lu_ctl", 32'({lu_c_and, lu_c_or, lu_c_xor, lu_c_inv}), 32'd0);
    check("mid_lu_a", 32'(lu_a), 32'd0);
    check("mid_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
    got_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_rsp", 32'(got_q.size()), 32'd0);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    // Pointer restarts favouring requester 0
    drive(0, 3'b000, 8'h0F, 8'hFF, 4'hC);
    drive(1, 3'b001, 8'h00, 8'h00, 4'hE);
    #1;
    check("post_rst_rr0", 32'(req0_ready), 32'd1);
    check("post_rst_rr1", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    send(0, 3'b000, 8'h0F, 8'hFF, 4'hC, 8'h0F, 1'b0);
    drain_and_compare("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
